// File: rtl/uart_pkg.sv
// Purpose: shared types and constants for the 8N1 UART receiver.
//   rx_state_e  : receiver FSM states
//   DATA_BITS   : payload bits per frame
//   CNT_W       : width of the bit-timing down counter
//   BIT_IDX_W   : width of the data-bit index
//   bit_cycles(): clock cycles per bit, rounded to nearest
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned CNT_W     = 20;
    localparam int unsigned BIT_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    // Rounded division so the bit period is as close as possible to the line rate.
    function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                               input int unsigned baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_buffer.sv
// Purpose: one-entry valid/ready output register for received bytes.
//   clk, reset     : clock, async active-low reset
//   in_data_i      : completed byte from the receiver FSM
//   in_valid_i     : single-cycle strobe, byte completed with good stop bit
//   ready_i        : consumer accepts the held byte this cycle
//   data_o/valid_o : held byte and its occupancy flag (registered)
//   drop_o         : 1-cycle pulse, incoming byte dropped because buffer stayed full
module uart_rx_buffer
    import uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] in_data_i,
    input  logic                 in_valid_i,
    input  logic                 ready_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 drop_o
);

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 drop_q, drop_d;

    // Load when empty or when the held byte leaves in the same cycle; otherwise drop.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        drop_d  = 1'b0;
        if (in_valid_i) begin
            if (!valid_q || ready_i) begin
                data_d  = in_data_i;
                valid_d = 1'b1;
            end else begin
                drop_d  = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign drop_o  = drop_q;

endmodule

// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver with a one-entry valid/ready output buffer.
//   clk, reset        : clock, async active-low reset
//   io_rxd            : asynchronous serial line, idle high
//   io_channel_data   : received byte, stable while io_channel_valid
//   io_channel_valid  : buffer holds an unconsumed byte
//   io_channel_ready  : consumer accepts the byte
//   io_frame_err      : 1-cycle pulse, stop bit sampled low
//   io_overrun        : 1-cycle pulse, byte completed while buffer full and dropped
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_rxd,
    output logic [DATA_BITS-1:0] io_channel_data,
    output logic                 io_channel_valid,
    input  logic                 io_channel_ready,
    output logic                 io_frame_err,
    output logic                 io_overrun
);

    localparam int unsigned      BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    logic                 rx_meta_q, rx_s_q;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0] bits_q, bits_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_err_q, frame_err_d;
    logic                 emit_c;

    // Two-flop synchroniser; reset to idle-high so reset release never fakes a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= io_rxd;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Next-state logic: half-bit wait in START puts every later sample at mid-bit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bits_d      = bits_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        emit_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = CNT_HALF;
                end
            end
            START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!rx_s_q) begin
                    state_d = DATA;
                    cnt_d   = CNT_FULL;
                    bits_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    cnt_d   = CNT_FULL;
                    if (bits_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bits_d = bits_q + BIT_IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    if (rx_s_q) begin
                        emit_c = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bits_q      <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bits_q      <= bits_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign io_frame_err = frame_err_q;

    uart_rx_buffer u_buffer (
        .clk       (clk),
        .reset     (reset),
        .in_data_i (shift_q),
        .in_valid_i(emit_c),
        .ready_i   (io_channel_ready),
        .data_o    (io_channel_data),
        .valid_o   (io_channel_valid),
        .drop_o    (io_overrun)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Purpose: self-checking bench for uart_rx at CLK_FREQ=1000, BAUD=100 (10 cycles/bit).
module tb_uart_rx;

    localparam int unsigned BITC = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       io_rxd = 1'b1;
    logic       io_channel_ready = 1'b1;
    logic [7:0] io_channel_data;
    logic       io_channel_valid;
    logic       io_frame_err;
    logic       io_overrun;

    uart_rx #(.CLK_FREQ(1000), .BAUD(100)) dut (
        .clk             (clk),
        .reset           (reset),
        .io_rxd          (io_rxd),
        .io_channel_data (io_channel_data),
        .io_channel_valid(io_channel_valid),
        .io_channel_ready(io_channel_ready),
        .io_frame_err    (io_frame_err),
        .io_overrun      (io_overrun)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;

    // Observations collected away from the active edge.
    logic [7:0] rx_q[$];
    int unsigned valid_cycles = 0;
    int unsigned ferr_cnt = 0;
    int unsigned ovr_cnt = 0;

    always @(negedge clk) begin
        if (io_channel_valid) valid_cycles++;
        if (io_channel_valid && io_channel_ready) rx_q.push_back(io_channel_data);
        if (io_frame_err) ferr_cnt++;
        if (io_overrun) ovr_cnt++;
    end

    // Reference model: list of bytes that must arrive, and baselines per test.
    logic [7:0] exp_q[$];
    int unsigned rx_base, vc_base, fe_base, ov_base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        io_rxd = b;
        tick(BITC);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop_b);
    endtask

    task automatic mark();
        rx_base = rx_q.size();
        vc_base = valid_cycles;
        fe_base = ferr_cnt;
        ov_base = ovr_cnt;
        exp_q.delete();
    endtask

    task automatic compare_bytes(input string tag);
        int unsigned got_n;
        logic [31:0] got;
        got_n = rx_q.size() - rx_base;
        check({tag, "_count"}, got_n, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (rx_base + i < rx_q.size()) ? 32'(rx_q[rx_base + i]) : 32'hDEAD;
            check($sformatf("%s_byte%0d", tag, i), got, 32'(exp_q[i]));
        end
    endtask

    initial begin
        logic [7:0] hello [5];
        logic [7:0] b;
        logic       stop_ok;
        int unsigned n_err;
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

        // Reset values
        tick(3);
        check("rst_valid", io_channel_valid, 0);
        check("rst_data", io_channel_data, 0);
        check("rst_ferr", io_frame_err, 0);
        check("rst_ovr", io_overrun, 0);
        reset = 1'b1;
        tick(5);

        // Single frame 0x48
        mark();
        exp_q.push_back(8'h48);
        send_frame(8'h48, 1'b1);
        tick(5);
        compare_bytes("t1");
        check("t1_valid_cycles", valid_cycles - vc_base, 1);
        check("t1_ferr", ferr_cnt - fe_base, 0);
        check("t1_ovr", ovr_cnt - ov_base, 0);

        // Short low glitch is rejected
        mark();
        io_rxd = 1'b0;
        tick(3);
        io_rxd = 1'b1;
        tick(30);
        check("t2_bytes", rx_q.size() - rx_base, 0);
        check("t2_valid_cycles", valid_cycles - vc_base, 0);
        check("t2_ferr", ferr_cnt - fe_base, 0);

        // Bad stop bit
        mark();
        send_frame(8'h65, 1'b0);
        io_rxd = 1'b1;
        tick(30);
        check("t3_ferr", ferr_cnt - fe_base, 1);
        check("t3_bytes", rx_q.size() - rx_base, 0);
        check("t3_valid_cycles", valid_cycles - vc_base, 0);

        // Overrun with consumer stalled
        mark();
        io_channel_ready = 1'b0;
        send_frame(8'h65, 1'b1);
        send_frame(8'h6C, 1'b1);
        tick(5);
        check("t4_valid_held", io_channel_valid, 1);
        check("t4_data_held", io_channel_data, 8'h65);
        check("t4_ovr", ovr_cnt - ov_base, 1);
        check("t4_ferr", ferr_cnt - fe_base, 0);
        check("t4_no_xfer", rx_q.size() - rx_base, 0);
        io_channel_ready = 1'b1;
        exp_q.push_back(8'h65);
        tick(3);
        compare_bytes("t4");
        check("t4_valid_clear", io_channel_valid, 0);

        // Back-to-back "Hello"
        mark();
        foreach (hello[i]) begin
            exp_q.push_back(hello[i]);
            send_frame(hello[i], 1'b1);
        end
        tick(5);
        compare_bytes("t5");
        check("t5_ferr", ferr_cnt - fe_base, 0);

        // Random bytes, random idle gaps, occasional bad stop bit
        mark();
        n_err = 0;
        for (int k = 0; k < 12; k++) begin
            b = 8'($urandom);
            stop_ok = ($urandom_range(0, 3) != 0);
            send_frame(b, stop_ok);
            io_rxd = 1'b1;
            if (stop_ok) begin
                exp_q.push_back(b);
                tick($urandom_range(0, 12));
            end else begin
                n_err++;
                tick(15 + $urandom_range(0, 10));
            end
        end
        tick(5);
        compare_bytes("rnd");
        check("rnd_ferr", ferr_cnt - fe_base, n_err);
        check("rnd_ovr", ovr_cnt - ov_base, 0);

        // Reset in the middle of a frame while a byte is buffered
        io_channel_ready = 1'b0;
        b = 8'($urandom_range(1, 255));
        send_frame(b, 1'b1);
        tick(5);
        check("t6_pre_valid", io_channel_valid, 1);
        check("t6_pre_data", io_channel_data, 32'(b));
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        io_rxd = 1'b1;
        tick(4);
        reset = 1'b0;
        #1;
        check("t6_rst_valid", io_channel_valid, 0);
        check("t6_rst_data", io_channel_data, 0);
        check("t6_rst_ferr", io_frame_err, 0);
        check("t6_rst_ovr", io_overrun, 0);
        tick(3);
        io_rxd = 1'b1;
        io_channel_ready = 1'b1;
        reset = 1'b1;
        tick(5);
        mark();
        exp_q.push_back(8'h48);
        send_frame(8'h48, 1'b1);
        tick(5);
        compare_bytes("t6");
        check("t6_ferr", ferr_cnt - fe_base, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
